// File: rtl/qe_bus_bridge_if.sv
// QL expansion-bus / W5300 signal bundle for qe_bus_bridge.
// master = QL side (drives address/strobes), slave = bridge.
interface qe_bus_bridge_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned NUM_WIZ = 1
);
  logic [ADDR_W-1:0]  address;
  logic [3:0]         sp;
  logic               asl;
  logic               dsl;
  logic               rdwl;
  logic               dtackl;
  logic               dsmcl;
  logic               dbenl;
  logic               dbdir;
  logic [NUM_WIZ-1:0] wizcsl;
  logic               wizrdl;
  logic               wizwrl;
  logic               wizrstl;

  modport master (
    output address, sp, asl, dsl, rdwl,
    input  dtackl, dsmcl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl
  );

  modport slave (
    input  address, sp, asl, dsl, rdwl,
    output dtackl, dsmcl, dbenl, dbdir, wizcsl, wizrdl, wizwrl, wizrstl
  );
endinterface

// File: rtl/qe_bus_bridge.sv
// Clocked QL expansion-bus to W5300 bridge.
// Synchronises asl/dsl/rdwl, decodes the card window, sequences chip-select and
// rd/wr strobes with setup/strobe/recovery timing, and generates dtackl/dsmcl and
// data-buffer control.
// Optional feature: define QE_RESET_REG_EN to make a write to window offset
// CTRL_OFFS pulse wizrstl (a software reset of the W5300s).
module qe_bus_bridge #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEC_W      = 2,
  parameter int unsigned BASE_ADDR  = 'h3,
  parameter int unsigned SLOT_ID    = 'h0,
  parameter int unsigned NUM_WIZ    = 1,
  parameter int unsigned CS_LSB     = 6,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned REC_CYC    = 1,
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned CTRL_OFFS  = 'hFF
) (
  input  logic            clk,
  input  logic            rst,
  qe_bus_bridge_if.slave  bus
);

  localparam int unsigned IDX_W   = (NUM_WIZ > 1) ? $clog2(NUM_WIZ) : 1;
  localparam int unsigned OFFS_W  = ADDR_W - DEC_W;
  localparam int unsigned CYC_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned CYC_MAX = (CYC_A > REC_CYC) ? CYC_A : REC_CYC;
  localparam int unsigned CW      = $clog2(CYC_MAX + 1);
  localparam int unsigned RW      = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_ACK, S_REC} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic               as_m_q, as_q, ds_m_q, ds_q, rw_m_q, rw_q;
  logic [IDX_W-1:0]   idx_q;
  logic               rd_q, dev_q, ctrl_q, dsmc_q;
  logic [RW-1:0]      rcnt_q;
  logic               rstl_q;

  logic               sp_match, win_match, sel, hit;
  logic               ctrl_sel, ctrl_en, ctrl_hit, dev_ok, ack_entry;
  logic [IDX_W-1:0]   idx_in;
  logic [NUM_WIZ-1:0] cs_act, wizcsl_c;
  logic               dtackl_c, dbenl_c, wizrdl_c, wizwrl_c;

  // Two-flop synchronisers for the asynchronous QL strobes and direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      as_m_q <= 1'b1; as_q <= 1'b1;
      ds_m_q <= 1'b1; ds_q <= 1'b1;
      rw_m_q <= 1'b1; rw_q <= 1'b1;
    end else begin
      as_m_q <= bus.asl;  as_q <= as_m_q;
      ds_m_q <= bus.dsl;  ds_q <= ds_m_q;
      rw_m_q <= bus.rdwl; rw_q <= rw_m_q;
    end
  end

  assign sp_match  = (bus.sp == 4'(SLOT_ID));
  assign win_match = (bus.address[ADDR_W-1 -: DEC_W] == DEC_W'(BASE_ADDR));
  assign sel       = sp_match & win_match;
  assign hit       = ~as_q & ~ds_q & sel;
  assign ctrl_sel  = (bus.address[OFFS_W-1:0] == OFFS_W'(CTRL_OFFS));
`ifdef QE_RESET_REG_EN
  assign ctrl_en   = 1'b1;
`else
  assign ctrl_en   = 1'b0;
`endif
  assign ctrl_hit  = ctrl_sel & ctrl_en;
  assign idx_in    = bus.address[CS_LSB +: IDX_W];
  // Out-of-range devices, control-location accesses and accesses during a
  // W5300 reset pulse still walk the FSM and ack, just without cs/strobe.
  assign dev_ok    = (32'(idx_in) < NUM_WIZ) & rstl_q & ~ctrl_hit;

  // Capture access attributes as the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      rd_q   <= 1'b0;
      dev_q  <= 1'b0;
      ctrl_q <= 1'b0;
    end else if (state_q == S_IDLE && hit) begin
      idx_q  <= idx_in;
      rd_q   <= rw_q;
      dev_q  <= dev_ok;
      ctrl_q <= ctrl_hit;
    end
  end

  // Motherboard memory-controller disable, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) dsmc_q <= 1'b1;
    else     dsmc_q <= ~(~as_q & sel);
  end

  // FSM state and phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  // Next-state logic; an address-strobe release during SETUP/STROBE aborts to REC.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: if (hit) begin
        state_d = S_SETUP;
        cyc_d   = CW'(SETUP_CYC - 1);
      end
      S_SETUP: begin
        if (as_q) begin
          state_d = S_REC;
          cyc_d   = CW'(REC_CYC - 1);
        end else if (cyc_q == '0) begin
          state_d = S_STROBE;
          cyc_d   = CW'(STROBE_CYC - 1);
        end else begin
          cyc_d   = cyc_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (as_q) begin
          state_d = S_REC;
          cyc_d   = CW'(REC_CYC - 1);
        end else if (cyc_q == '0) begin
          state_d = S_ACK;
        end else begin
          cyc_d   = cyc_q - CW'(1);
        end
      end
      S_ACK: if (as_q) begin
        state_d = S_REC;
        cyc_d   = CW'(REC_CYC - 1);
      end
      S_REC: begin
        if (cyc_q == '0) state_d = S_IDLE;
        else             cyc_d   = cyc_q - CW'(1);
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  assign ack_entry = (state_q == S_STROBE) && (state_d == S_ACK);

  // W5300 reset pulse: after rst, and restarted by a control-location write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= RW'(RST_CYCLES);
      rstl_q <= 1'b0;
    end else if (ack_entry && ctrl_q && !rd_q) begin
      rcnt_q <= RW'(RST_CYCLES);
      rstl_q <= 1'b0;
    end else if (rcnt_q != '0) begin
      rcnt_q <= rcnt_q - RW'(1);
      rstl_q <= (rcnt_q == RW'(1));
    end
  end

  // Bus and W5300 control outputs decoded from the current state.
  always_comb begin
    cs_act = '1;
    for (int unsigned i = 0; i < NUM_WIZ; i++) begin
      if (dev_q && idx_q == IDX_W'(i)) cs_act[i] = 1'b0;
    end
    wizcsl_c = '1;
    dtackl_c = 1'b1;
    dbenl_c  = 1'b1;
    wizrdl_c = 1'b1;
    wizwrl_c = 1'b1;
    case (state_q)
      S_SETUP: begin
        wizcsl_c = cs_act;
        dbenl_c  = ctrl_q;
      end
      S_STROBE: begin
        wizcsl_c = cs_act;
        dbenl_c  = ctrl_q;
        wizrdl_c = ~(dev_q & rd_q);
        wizwrl_c = ~(dev_q & ~rd_q);
      end
      S_ACK: begin
        wizcsl_c = cs_act;
        dbenl_c  = ctrl_q;
        dtackl_c = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.dtackl  = dtackl_c;
  assign bus.dsmcl   = dsmc_q;
  assign bus.dbenl   = dbenl_c;
  assign bus.dbdir   = rd_q;
  assign bus.wizcsl  = wizcsl_c;
  assign bus.wizrdl  = wizrdl_c;
  assign bus.wizwrl  = wizwrl_c;
  assign bus.wizrstl = rstl_q;

endmodule

// File: tb/tb_qe_bus_bridge.sv
// Directed, table-driven bench for qe_bus_bridge: one instance with NUM_WIZ=1 and
// one with NUM_WIZ=2, both driven with identical QL bus traffic.
module tb_qe_bus_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qe_bus_bridge_if #(.ADDR_W(10), .NUM_WIZ(1)) bus1 ();
  qe_bus_bridge_if #(.ADDR_W(10), .NUM_WIZ(2)) bus2 ();

  qe_bus_bridge #(.NUM_WIZ(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  qe_bus_bridge #(.NUM_WIZ(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [9:0] addr;
    logic [3:0] sp;
    logic       rdwl;
    int         rel;      // sample edge after which asl/dsl are released
    bit         pre_rst;  // pulse rst just before the access
    int e_cs2f, e_stb2f, e_rd1, e_wr1, e_rd2, e_wr2;
    int e_dtkf, e_dtkn, e_dben, e_dsmc, e_cs1, e_cs2, e_dbdir, e_rstl;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [9:0] a, input logic [3:0] s, input logic rw,
                              input int rel, input bit pr,
                              input int cs2f, input int stb2f, input int rd1, input int wr1,
                              input int rd2, input int wr2, input int dtkf, input int dtkn,
                              input int dben, input int dsmc, input int cs1, input int cs2,
                              input int dbdir, input int rstl);
    vec_t v;
    v.addr = a; v.sp = s; v.rdwl = rw; v.rel = rel; v.pre_rst = pr;
    v.e_cs2f = cs2f; v.e_stb2f = stb2f; v.e_rd1 = rd1; v.e_wr1 = wr1;
    v.e_rd2 = rd2; v.e_wr2 = wr2; v.e_dtkf = dtkf; v.e_dtkn = dtkn;
    v.e_dben = dben; v.e_dsmc = dsmc; v.e_cs1 = cs1; v.e_cs2 = cs2;
    v.e_dbdir = dbdir; v.e_rstl = rstl;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] a, input logic [3:0] s, input logic rw, input logic strb);
    bus1.address = a; bus1.sp = s; bus1.rdwl = rw; bus1.asl = strb; bus1.dsl = strb;
    bus2.address = a; bus2.sp = s; bus2.rdwl = rw; bus2.asl = strb; bus2.dsl = strb;
  endtask

  function automatic int pack1();
    return int'({bus1.dtackl, bus1.dsmcl, bus1.dbenl, bus1.dbdir,
                 bus1.wizcsl[0], bus1.wizrdl, bus1.wizwrl, bus1.wizrstl});
  endfunction

  initial begin
    int n;
    // addr    sp  rw  rel pr  cs2f stb rd1 wr1 rd2 wr2 dtkf dtkn dben dsmc cs1 cs2 dbdir rstl
    vecs[0] = mk(10'h30E, 4'h0, 1'b0, 6, 1'b0, 3, 4, 0, 2, 0, 2, 6, 3, 6, 6, 0, 2, 0, 0);
    vecs[1] = mk(10'h30F, 4'h0, 1'b1, 6, 1'b0, 3, 4, 2, 0, 2, 0, 6, 3, 6, 6, 0, 2, 1, 0);
    vecs[2] = mk(10'h133, 4'h0, 1'b1, 6, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0);
    vecs[3] = mk(10'h30E, 4'h3, 1'b0, 6, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0);
    vecs[4] = mk(10'h340, 4'h0, 1'b0, 6, 1'b0, 3, 4, 0, 0, 0, 2, 6, 3, 6, 6, 1, 1, 0, 0);
    vecs[5] = mk(10'h300, 4'h0, 1'b1, 6, 1'b0, 3, 4, 2, 0, 2, 0, 6, 3, 6, 6, 0, 2, 1, 0);
    vecs[6] = mk(10'h30E, 4'h0, 1'b0, 2, 1'b0, 3, 4, 0, 1, 0, 1, 0, 0, 2, 2, 0, 2, 0, 0);
`ifdef QE_RESET_REG_EN
    vecs[7] = mk(10'h3FF, 4'h0, 1'b0, 6, 1'b0, 0, 0, 0, 0, 0, 0, 6, 3, 0, 6, 1, 3, 0, 16);
`else
    vecs[7] = mk(10'h3FF, 4'h0, 1'b0, 6, 1'b0, 3, 4, 0, 0, 0, 2, 6, 3, 6, 6, 1, 1, 0, 0);
`endif
    vecs[8] = mk(10'h30E, 4'h0, 1'b0, 6, 1'b1, 0, 0, 0, 0, 0, 0, 6, 3, 6, 6, 1, 3, 0, 15);

    // Reset values, then wizrstl low for RST_CYCLES clocks after rst falls.
    drive(10'h000, 4'hF, 1'b1, 1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", pack1(), 8'hEE);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus1.wizrstl) break;
    end
    check("rst_pulse_len", n, 16);
    check("post_rst_outputs", pack1(), 8'hEF);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      int cs2f, stbf, rd1, wr1, rd2, wr2, dtkf, dtkn, dben, dsmc, dbdir, rstl;
      logic       cs1acc;
      logic [1:0] cs2acc;
      cs2f = 0; stbf = 0; rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0; dtkf = 0; dtkn = 0;
      dben = 0; dsmc = 0; dbdir = 0; rstl = 0; cs1acc = 1'b1; cs2acc = 2'b11;
      @(negedge clk);
      if (vecs[i].pre_rst) begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      drive(vecs[i].addr, vecs[i].sp, vecs[i].rdwl, 1'b0);
      for (int k = 1; k <= 24; k++) begin
        @(posedge clk); #1;
        if (bus2.wizcsl != 2'b11 && cs2f == 0) cs2f = k;
        if ((!bus2.wizrdl || !bus2.wizwrl) && stbf == 0) stbf = k;
        rd1 += int'(!bus1.wizrdl); wr1 += int'(!bus1.wizwrl);
        rd2 += int'(!bus2.wizrdl); wr2 += int'(!bus2.wizwrl);
        if (!bus1.dtackl && dtkf == 0) dtkf = k;
        dtkn += int'(!bus1.dtackl);
        dben += int'(!bus1.dbenl);
        dsmc += int'(!bus1.dsmcl);
        rstl += int'(!bus1.wizrstl);
        cs1acc &= bus1.wizcsl[0];
        cs2acc &= bus2.wizcsl;
        if (k == 4) dbdir = int'(bus1.dbdir);
        if (k == vecs[i].rel) begin
          @(negedge clk);
          bus1.asl = 1'b1; bus1.dsl = 1'b1;
          bus2.asl = 1'b1; bus2.dsl = 1'b1;
        end
      end
      check($sformatf("v%0d cs2_first", i), cs2f, vecs[i].e_cs2f);
      check($sformatf("v%0d strobe2_first", i), stbf, vecs[i].e_stb2f);
      check($sformatf("v%0d rd1_len", i), rd1, vecs[i].e_rd1);
      check($sformatf("v%0d wr1_len", i), wr1, vecs[i].e_wr1);
      check($sformatf("v%0d rd2_len", i), rd2, vecs[i].e_rd2);
      check($sformatf("v%0d wr2_len", i), wr2, vecs[i].e_wr2);
      check($sformatf("v%0d dtack_first", i), dtkf, vecs[i].e_dtkf);
      check($sformatf("v%0d dtack_len", i), dtkn, vecs[i].e_dtkn);
      check($sformatf("v%0d dbenl_len", i), dben, vecs[i].e_dben);
      check($sformatf("v%0d dsmcl_len", i), dsmc, vecs[i].e_dsmc);
      check($sformatf("v%0d cs1", i), int'(cs1acc), vecs[i].e_cs1);
      check($sformatf("v%0d cs2", i), int'(cs2acc), vecs[i].e_cs2);
      check($sformatf("v%0d dbdir", i), dbdir, vecs[i].e_dbdir);
      check($sformatf("v%0d wizrstl_low", i), rstl, vecs[i].e_rstl);
    end

    // rst asserted mid-strobe: every output back at its reset value next edge.
    @(negedge clk);
    drive(10'h30E, 4'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 check("midrst_wr_active", int'(bus1.wizwrl), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", pack1(), 8'hEE);
    check("midrst_cs2", int'(bus2.wizcsl), 3);
    @(negedge clk);
    drive(10'h000, 4'hF, 1'b1, 1'b1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
